led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised multi-channel LED driver that generalises the single free-running blink counter. Each channel independently runs one of four modes: off, on, blink or breathe (triangle-ramped PWM). All channels share one prescaler tick. Channels are reconfigured at run time through a valid/ready write port. It sits at the top level of the fabric design and drives board LEDs as a liveness and status indicator.

Parameters:
CHANNELS, 4, number of LED outputs (1..16)
PRESCALE_WIDTH, 16, width of the shared prescaler counter
PRESCALE_DIV, 50000, clk cycles per tick (2..2^PRESCALE_WIDTH)
RATE_WIDTH, 8, width of the per-channel rate field
PWM_WIDTH, 8, PWM resolution; MAX = 2^PWM_WIDTH-1
DEFAULT_MODE, 2, mode of every channel after reset (0 off, 1 on, 2 blink, 3 breathe)
DEFAULT_RATE, 255, rate of every channel after reset

Ports:
clk  input  1  single clock
resetn  input  1  asynchronous active-low reset
cfg_valid  input  1  config write request
cfg_ready  output  1  config port can accept
cfg_ch  input  4  target channel index
cfg_mode  input  2  new mode
cfg_rate  input  RATE_WIDTH  new rate
cfg_err  output  1  one-cycle pulse: write to a nonexistent channel
led  output  CHANNELS  LED drive, bit i = channel i

Behaviour:
- Reset: resetn low asynchronously clears all state.
  - Internal 2-flop synchroniser: asserts asynchronously, releases synchronously.
  - Internal reset deasserts on the 2nd rising clk edge after resetn rises.
  - Reset values: led=0, cfg_ready=0, cfg_err=0, prescaler=0, pwm_cnt=0.
  - Per channel at reset: mode=DEFAULT_MODE, rate=DEFAULT_RATE, rate_cnt=0, blink=0, duty=0, dir=up.
  - resetn low mid-operation aborts everything immediately. Any in-flight cfg write is lost.
- Prescaler:
  - Counts 0..PRESCALE_DIV-1, then wraps to 0.
  - tick is high for exactly one cycle when the count is PRESCALE_DIV-1.
- PWM counter: free-running PWM_WIDTH bits, +1 every clk, wraps MAX->0.
- Config handshake:
  - cfg_ready=1 whenever internal reset is released.
  - A write is accepted on a cycle with cfg_valid & cfg_ready.
  - Valid cfg_ch < CHANNELS: on the next edge the channel loads mode=cfg_mode and rate=cfg_rate, and sets rate_cnt=0, blink=0, duty=0, dir=up.
  - Invalid cfg_ch >= CHANNELS: no state changes; cfg_err=1 for the following cycle only.
  - Writing the same mode/rate still restarts the channel's pattern.
  - A write and a tick in the same cycle: the written channel takes the write, ignores that tick, and has no rate_cnt advance. Other channels advance normally.
- Rate stepping (modes 2, 3):
  - On each tick, if rate_cnt==rate: rate_cnt<=0 and a step occurs; else rate_cnt+1.
  - A step therefore occurs every (rate+1) ticks. rate=0 steps every tick.
- Mode 0: channel output 0. Mode 1: channel output 1. Counters hold in both.
- Mode 2 (blink):
  - Each step toggles blink. Output = blink.
  - Full LED period = 2*(rate+1)*PRESCALE_DIV cycles.
- Mode 3 (breathe):
  - Each step moves duty:
    - dir up, duty<MAX: duty+1.
    - dir up, duty==MAX: dir=down, duty=MAX-1.
    - dir down, duty>0: duty-1.
    - dir down, duty==0: dir=up, duty=1.
  - Output = (pwm_cnt < duty). duty=0 gives a constant 0.
- Output latency: led is registered, one cycle after the internal state that produces it. It is glitch-free.
- All arithmetic is unsigned and wraps within the declared widths; no saturation except the duty ramp.

Test Plan:
- Bench parameters: PRESCALE_DIV=4, PWM_WIDTH=2, DEFAULT_MODE=2, DEFAULT_RATE=1.
- Reset release: hold resetn=0 for 5 clk, then raise -> cfg_ready rises on the 2nd edge. All led=0 until the first toggle, then every channel toggles every 8 clk (16-clk period).
- Blink rate write: cfg_ch=0, mode=2, rate=0 -> led[0] returns to 0, then toggles every 4 clk. Channels 1..3 are unaffected.
- Breathe ramp: cfg_ch=1, mode=3, rate=0 -> duty steps 1,2,3,2,1,0,1 every 4 clk. At duty=2, led[1] is high 2 of every 4 clk.
- Static and invalid: mode=1 on ch2 -> led[2]=1 constant. cfg_ch=7 -> cfg_err high for exactly one cycle and no led change.
- Collision and mid-run reset: issue a write to ch3 on a tick cycle -> ch3 restarts with blink=0. Drop resetn for 1 clk mid-pattern -> led=0 and cfg_ready=0 immediately, and defaults return.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: multi-channel LED driver (off / on / blink / breathe)
// sharing one prescaler tick, reconfigured through a valid/ready port.
module led_pattern_gen #(
  parameter int CHANNELS       = 4,
  parameter int PRESCALE_WIDTH = 16,
  parameter int PRESCALE_DIV   = 50000,
  parameter int RATE_WIDTH     = 8,
  parameter int PWM_WIDTH      = 8,
  parameter int DEFAULT_MODE   = 2,
  parameter int DEFAULT_RATE   = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [3:0]            cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [RATE_WIDTH-1:0] cfg_rate,
  output logic                  cfg_err,
  output logic [CHANNELS-1:0]   led
);

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_ON,
    MODE_BLINK,
    MODE_BREATHE
  } mode_e;

  localparam logic [PRESCALE_WIDTH-1:0] PRE_LAST =
    PRESCALE_WIDTH'(PRESCALE_DIV - 1);
  localparam logic [PWM_WIDTH-1:0] PWM_MAX = '1;
  localparam logic [PWM_WIDTH-1:0] PWM_ONE = PWM_WIDTH'(1);

  logic rst_meta;
  logic rst_n;

  // Reset asserts at once, releases two edges after resetn rises.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  assign cfg_ready = rst_n;

  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [PWM_WIDTH-1:0]      pwm_cnt;
  logic                      tick;

  assign tick = (pre_cnt == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  logic accept;
  logic ch_ok;

  assign accept = cfg_valid & cfg_ready;
  assign ch_ok  = {1'b0, cfg_ch} < 5'(CHANNELS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err <= 1'b0;
    else        cfg_err <= accept & ~ch_ok;
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    mode_e                 mode;
    logic [RATE_WIDTH-1:0] rate;
    logic [RATE_WIDTH-1:0] rate_cnt;
    logic [PWM_WIDTH-1:0]  duty;
    logic                  blink;
    logic                  down;
    logic                  out;
    logic                  hit;
    logic                  run;
    logic                  step;

    assign hit    = accept & ch_ok & (cfg_ch == 4'(i));
    assign run    = (mode == MODE_BLINK) | (mode == MODE_BREATHE);
    assign step   = tick & (rate_cnt == rate);
    assign led[i] = out;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mode     <= mode_e'(2'(DEFAULT_MODE));
        rate     <= RATE_WIDTH'(DEFAULT_RATE);
        rate_cnt <= '0;
        duty     <= '0;
        blink    <= 1'b0;
        down     <= 1'b0;
        out      <= 1'b0;
      end else begin
        unique case (mode)
          MODE_OFF:     out <= 1'b0;
          MODE_ON:      out <= 1'b1;
          MODE_BLINK:   out <= blink;
          MODE_BREATHE: out <= (pwm_cnt < duty);
        endcase
        // A write wins over a coincident tick for this channel.
        if (hit) begin
          mode     <= mode_e'(cfg_mode);
          rate     <= cfg_rate;
          rate_cnt <= '0;
          duty     <= '0;
          blink    <= 1'b0;
          down     <= 1'b0;
        end else if (tick && run) begin
          rate_cnt <= step ? '0 : rate_cnt + 1'b1;
          if (step && mode == MODE_BLINK) blink <= ~blink;
          if (step && mode == MODE_BREATHE) begin
            unique case (1'b1)
              !down && duty != PWM_MAX: duty <= duty + 1'b1;
              !down && duty == PWM_MAX: begin
                down <= 1'b1;
                duty <= PWM_MAX - 1'b1;
              end
              down && duty != '0: duty <= duty - 1'b1;
              down && duty == '0: begin
                down <= 1'b0;
                duty <= PWM_ONE;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench for led_pattern_gen with a
// tick-count model of blink/breathe built from period formulas.
module tb_led_pattern_gen;

  localparam int CH   = 4;
  localparam int DIV  = 4;
  localparam int PMAX = 3;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_ch = 4'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_rate = 8'd0;
  logic          cfg_ready;
  logic          cfg_err;
  logic [CH-1:0] led;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [CH-1:0] led;
    logic          ready;
    logic          err;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CHANNELS(CH),
    .PRESCALE_WIDTH(16),
    .PRESCALE_DIV(DIV),
    .RATE_WIDTH(8),
    .PWM_WIDTH(2),
    .DEFAULT_MODE(2),
    .DEFAULT_RATE(1)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode),
    .cfg_rate(cfg_rate),
    .cfg_err(cfg_err),
    .led(led)
  );

  logic m_s1 = 1'b0;
  logic m_s2 = 1'b0;
  int   m_pre = 0;
  int   m_pwm = 0;
  int   m_mode[CH] = '{default: 2};
  int   m_rate[CH] = '{default: 1};
  int   m_ticks[CH] = '{default: 0};

  // Output from ticks elapsed since restart: one step per rate+1 ticks.
  function automatic logic m_out(int i);
    int st;
    int s;
    int d;
    st = m_ticks[i] / (m_rate[i] + 1);
    s  = st % (2 * PMAX);
    d  = (s <= PMAX) ? s : 2 * PMAX - s;
    case (m_mode[i])
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'((st % 2) != 0);
      default: return 1'(m_pwm < d);
    endcase
  endfunction

  always begin
    exp_t e;
    logic acc;
    logic tk;
    @(posedge clk or negedge resetn);
    e = '0;
    if (!resetn) begin
      m_s1 = 1'b0;
      m_s2 = 1'b0;
      m_pre = 0;
      m_pwm = 0;
      for (int i = 0; i < CH; i++) begin
        m_mode[i] = 2;
        m_rate[i] = 1;
        m_ticks[i] = 0;
      end
      if (clk) q.push_back(e);
    end else if (!m_s2) begin
      m_s2 = m_s1;
      m_s1 = 1'b1;
      e.ready = m_s2;
      q.push_back(e);
    end else begin
      acc = cfg_valid;
      tk = (m_pre == DIV - 1);
      for (int i = 0; i < CH; i++) e.led[i] = m_out(i);
      e.ready = 1'b1;
      e.err = acc && (cfg_ch >= 4'(CH));
      for (int i = 0; i < CH; i++) begin
        if (acc && cfg_ch == 4'(i)) begin
          m_mode[i] = int'(cfg_mode);
          m_rate[i] = int'(cfg_rate);
          m_ticks[i] = 0;
        end else if (tk && m_mode[i] >= 2) begin
          m_ticks[i] = m_ticks[i] + 1;
        end
      end
      m_pre = (m_pre + 1) % DIV;
      m_pwm = (m_pwm + 1) % (PMAX + 1);
      q.push_back(e);
    end
  end

  task automatic test_reset();
    exp_t e;
    int rise = -1;
    resetn = 1'b0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL reset_sb queue empty at %0t", $time);
      end else begin
        e = q.pop_front(); n_chk++;
        if ({led, cfg_ready, cfg_err} !== e) begin
          n_fail++;
          $display("FAIL reset_sb t=%0t got %b%b%b expected %b",
                   $time, led, cfg_ready, cfg_err, e);
        end
      end
      if (j >= 5 && rise < 0 && cfg_ready === 1'b1) rise = j - 4;
      if (j == 4) resetn = 1'b1;
    end
    n_chk++;
    if (rise !== 2) begin
      n_fail++;
      $display("FAIL reset_ready_edge got %0d expected 2", rise);
    end
  endtask

  task automatic test_blink_default();
    exp_t e;
    logic [CH-1:0] prev = '0;
    int last = -1;
    int first = -1;
    int bad = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL blink_default_sb queue empty at %0t", $time);
      end else begin
        e = q.pop_front(); n_chk++;
        if ({led, cfg_ready, cfg_err} !== e) begin
          n_fail++;
          $display("FAIL blink_default_sb t=%0t got %b%b%b expected %b",
                   $time, led, cfg_ready, cfg_err, e);
        end
      end
      if (led !== 4'h0 && led !== 4'hF) bad++;
      if (j > 0 && led !== prev) begin
        if (first < 0) first = j;
        if (last >= 0) begin
          n_chk++;
          if (j - last !== 8) begin
            n_fail++;
            $display("FAIL blink_default_period got %0d expected 8",
                     j - last);
          end
        end
        last = j;
      end
      prev = led;
    end
    n_chk++;
    if (first !== 6) begin
      n_fail++;
      $display("FAIL blink_default_first got %0d expected 6", first);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL blink_default_sync got %0d unsynced expected 0", bad);
    end
  endtask

  task automatic test_blink_rate();
    exp_t e;
    logic prev = 1'b0;
    int last = -1;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL blink_rate_sb queue empty at %0t", $time);
      end else begin
        e = q.pop_front(); n_chk++;
        if ({led, cfg_ready, cfg_err} !== e) begin
          n_fail++;
          $display("FAIL blink_rate_sb t=%0t got %b%b%b expected %b",
                   $time, led, cfg_ready, cfg_err, e);
        end
      end
      if (j == 2) begin
        n_chk++;
        if (led[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL blink_rate_restart got %b expected 0", led[0]);
        end
      end
      if (j >= 3 && led[0] !== prev) begin
        if (last >= 0) begin
          n_chk++;
          if (j - last !== 4) begin
            n_fail++;
            $display("FAIL blink_rate_period got %0d expected 4",
                     j - last);
          end
        end
        last = j;
      end
      prev = led[0];
      if (j == 0) begin
        cfg_valid = 1'b1; cfg_ch = 4'd0;
        cfg_mode = 2'd2; cfg_rate = 8'd0;
      end
      if (j == 1) cfg_valid = 1'b0;
    end
  endtask

  task automatic test_breathe();
    exp_t e;
    int highs = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL breathe_sb queue empty at %0t", $time);
      end else begin
        e = q.pop_front(); n_chk++;
        if ({led, cfg_ready, cfg_err} !== e) begin
          n_fail++;
          $display("FAIL breathe_sb t=%0t got %b%b%b expected %b",
                   $time, led, cfg_ready, cfg_err, e);
        end
      end
      if (j >= 3 && j <= 26 && led[1] === 1'b1) highs++;
      if (j == 0) begin
        cfg_valid = 1'b1; cfg_ch = 4'd1;
        cfg_mode = 2'd3; cfg_rate = 8'd0;
      end
      if (j == 1) cfg_valid = 1'b0;
    end
    n_chk++;
    if (highs !== 9) begin
      n_fail++;
      $display("FAIL breathe_period_highs got %0d expected 9", highs);
    end
  endtask

  task automatic test_static_invalid();
    exp_t e;
    int low2 = 0;
    int errs = 0;
    int err_at = -1;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL static_sb queue empty at %0t", $time);
      end else begin
        e = q.pop_front(); n_chk++;
        if ({led, cfg_ready, cfg_err} !== e) begin
          n_fail++;
          $display("FAIL static_sb t=%0t got %b%b%b expected %b",
                   $time, led, cfg_ready, cfg_err, e);
        end
      end
      if (j >= 2 && led[2] !== 1'b1) low2++;
      if (cfg_err === 1'b1) begin
        errs++;
        err_at = j;
      end
      if (j == 0) begin
        cfg_valid = 1'b1; cfg_ch = 4'd2;
        cfg_mode = 2'd1; cfg_rate = 8'd0;
      end
      if (j == 1) cfg_valid = 1'b0;
      if (j == 4) begin
        cfg_valid = 1'b1; cfg_ch = 4'd7;
        cfg_mode = 2'd0; cfg_rate = 8'd0;
      end
      if (j == 5) cfg_valid = 1'b0;
    end
    n_chk++;
    if (low2 !== 0) begin
      n_fail++;
      $display("FAIL static_on got %0d low cycles expected 0", low2);
    end
    n_chk++;
    if (errs !== 1 || err_at !== 5) begin
      n_fail++;
      $display("FAIL invalid_err got %0d pulses at %0d expected 1 at 5",
               errs, err_at);
    end
  endtask

  task automatic test_collision();
    exp_t e;
    int rise = -1;
    logic found = 1'b0;
    for (int j = 0; j < 8 && !found; j++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL collision_sb queue empty at %0t", $time);
      end else begin
        e = q.pop_front(); n_chk++;
        if ({led, cfg_ready, cfg_err} !== e) begin
          n_fail++;
          $display("FAIL collision_sb t=%0t got %b%b%b expected %b",
                   $time, led, cfg_ready, cfg_err, e);
        end
      end
      if (m_pre == DIV - 1) begin
        found = 1'b1;
        cfg_valid = 1'b1; cfg_ch = 4'd3;
        cfg_mode = 2'd2; cfg_rate = 8'd1;
      end
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL collision_tick_wait got none expected tick in 8");
    end
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL collision_sb queue empty at %0t", $time);
      end else begin
        e = q.pop_front(); n_chk++;
        if ({led, cfg_ready, cfg_err} !== e) begin
          n_fail++;
          $display("FAIL collision_sb t=%0t got %b%b%b expected %b",
                   $time, led, cfg_ready, cfg_err, e);
        end
      end
      if (j >= 2 && rise < 0 && led[3] === 1'b1) rise = j;
      if (j == 0) cfg_valid = 1'b0;
    end
    n_chk++;
    if (rise !== 9) begin
      n_fail++;
      $display("FAIL collision_first_rise got %0d expected 9", rise);
    end
  endtask

  task automatic test_midrun_reset();
    exp_t e;
    int highs = 0;
    int bad = 0;
    cfg_valid = 1'b1; cfg_ch = 4'd0;
    cfg_mode = 2'd1; cfg_rate = 8'd5;
    #2 resetn = 1'b0;
    #1;
    n_chk++;
    if (led !== 4'h0 || cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_async got %b%b%b expected 000000",
               led, cfg_ready, cfg_err);
    end
    for (int j = 0; j <= 30; j++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL midrun_sb queue empty at %0t", $time);
      end else begin
        e = q.pop_front(); n_chk++;
        if ({led, cfg_ready, cfg_err} !== e) begin
          n_fail++;
          $display("FAIL midrun_sb t=%0t got %b%b%b expected %b",
                   $time, led, cfg_ready, cfg_err, e);
        end
      end
      if (j >= 1) begin
        if (led[0] === 1'b1) highs++;
        if (led !== 4'h0 && led !== 4'hF) bad++;
      end
      if (j == 0) begin
        resetn = 1'b1;
        cfg_valid = 1'b0;
      end
    end
    n_chk++;
    if (highs !== 12) begin
      n_fail++;
      $display("FAIL midrun_defaults got %0d high cycles expected 12",
               highs);
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL midrun_sync got %0d unsynced expected 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_blink_default();
    test_blink_rate();
    test_breathe();
    test_static_invalid();
    test_collision();
    test_midrun_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
